// File: rtl/matrix_input_mode.sv
`default_nettype none
// ============================================================================
//  Module      : matrix_input_mode
//  Description : Loads an m x n matrix received over UART into a BRAM slot
//                granted by the matrix manager, then replies 'K' or 'E'.
//  Revision    : 1.0 - initial release
// ============================================================================
module matrix_input_mode #(
    parameter int          ELEMENT_WIDTH  = 8,
    parameter int          ADDR_WIDTH     = 10,
    parameter int unsigned TIMEOUT_CYCLES = 100_000_000
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     mode_active,
    input  logic [3:0]               config_max_dim,
    input  logic [7:0]               rx_data,
    input  logic                     rx_valid,
    output logic                     clear_rx_buffer,
    output logic [7:0]               tx_data,
    output logic                     tx_start,
    input  logic                     tx_busy,
    output logic                     alloc_req,
    output logic [3:0]               alloc_m,
    output logic [3:0]               alloc_n,
    input  logic                     alloc_ack,
    input  logic                     alloc_fail,
    input  logic [ADDR_WIDTH-1:0]    alloc_addr,
    input  logic [3:0]               alloc_slot,
    output logic                     mem_wr_en,
    output logic [ADDR_WIDTH-1:0]    mem_wr_addr,
    output logic [ELEMENT_WIDTH-1:0] mem_wr_data,
    output logic                     commit_valid,
    output logic [3:0]               commit_slot,
    output logic [3:0]               error_code,
    output logic [3:0]               sub_state
);

    typedef enum logic [3:0] {
        ST_IDLE   = 4'd0,
        ST_GET_M  = 4'd1,
        ST_GET_N  = 4'd2,
        ST_ALLOC  = 4'd3,
        ST_RECV   = 4'd4,
        ST_COMMIT = 4'd5,
        ST_SEND   = 4'd6,
        ST_DONE   = 4'd7,
        ST_ERROR  = 4'd8
    } state_t;

    localparam logic [3:0]  c_ERR_NONE    = 4'd0;
    localparam logic [3:0]  c_ERR_DIM     = 4'd1;
    localparam logic [3:0]  c_ERR_ALLOC   = 4'd2;
    localparam logic [3:0]  c_ERR_TIMEOUT = 4'd3;
    localparam logic [7:0]  c_TX_OK       = 8'h4B;
    localparam logic [7:0]  c_TX_ERR      = 8'h45;
    localparam logic [31:0] c_TIMEOUT_LAST = 32'(TIMEOUT_CYCLES - 1);

    state_t                r_state;
    logic [7:0]            r_m;
    logic [7:0]            r_total;
    logic [7:0]            r_idx;
    logic [ADDR_WIDTH-1:0] r_base;
    logic [3:0]            r_slot;
    logic [31:0]           r_timeout;

    logic                     w_m_bad;
    logic                     w_n_bad;
    logic [7:0]               w_total;
    logic                     w_timeout_hit;
    logic [ADDR_WIDTH-1:0]    w_wr_addr;
    logic [ELEMENT_WIDTH-1:0] w_elem;

    // Dimensions are checked as full bytes so values above 15 are rejected, not wrapped.
    assign w_m_bad       = (r_m == 8'd0) || (r_m > {4'd0, config_max_dim});
    assign w_n_bad       = (rx_data == 8'd0) || (rx_data > {4'd0, config_max_dim});
    assign w_total       = {4'd0, r_m[3:0]} * {4'd0, rx_data[3:0]};
    assign w_timeout_hit = (r_timeout == c_TIMEOUT_LAST);
    assign w_wr_addr     = r_base + ADDR_WIDTH'(r_idx);
    assign w_elem        = ELEMENT_WIDTH'(rx_data);
    assign sub_state     = r_state;

    always_ff @(posedge clk) begin
        if (rst || !mode_active) begin
            r_state         <= ST_IDLE;
            r_m             <= 8'd0;
            r_total         <= 8'd0;
            r_idx           <= 8'd0;
            r_base          <= '0;
            r_slot          <= 4'd0;
            r_timeout       <= 32'd0;
            clear_rx_buffer <= 1'b0;
            tx_data         <= 8'd0;
            tx_start        <= 1'b0;
            alloc_req       <= 1'b0;
            alloc_m         <= 4'd0;
            alloc_n         <= 4'd0;
            mem_wr_en       <= 1'b0;
            mem_wr_addr     <= '0;
            mem_wr_data     <= '0;
            commit_valid    <= 1'b0;
            commit_slot     <= 4'd0;
            error_code      <= c_ERR_NONE;
        end else begin
            clear_rx_buffer <= 1'b0;
            tx_start        <= 1'b0;
            mem_wr_en       <= 1'b0;
            commit_valid    <= 1'b0;

            case (r_state)
                ST_IDLE: begin
                    r_state         <= ST_GET_M;
                    clear_rx_buffer <= 1'b1;
                    r_timeout       <= 32'd0;
                end

                ST_GET_M: begin
                    if (rx_valid) begin
                        r_m        <= rx_data;
                        error_code <= c_ERR_NONE;
                        r_timeout  <= 32'd0;
                        r_state    <= ST_GET_N;
                    end
                end

                ST_GET_N: begin
                    if (rx_valid) begin
                        r_timeout <= 32'd0;
                        if (w_m_bad || w_n_bad) begin
                            error_code      <= c_ERR_DIM;
                            clear_rx_buffer <= 1'b1;
                            r_state         <= ST_ERROR;
                        end else begin
                            r_total   <= w_total;
                            alloc_req <= 1'b1;
                            alloc_m   <= r_m[3:0];
                            alloc_n   <= rx_data[3:0];
                            r_state   <= ST_ALLOC;
                        end
                    end else if (w_timeout_hit) begin
                        error_code      <= c_ERR_TIMEOUT;
                        clear_rx_buffer <= 1'b1;
                        r_state         <= ST_ERROR;
                    end else begin
                        r_timeout <= r_timeout + 32'd1;
                    end
                end

                // A grant outranks a simultaneous failure strobe.
                ST_ALLOC: begin
                    if (alloc_ack) begin
                        r_base    <= alloc_addr;
                        r_slot    <= alloc_slot;
                        r_idx     <= 8'd0;
                        r_timeout <= 32'd0;
                        alloc_req <= 1'b0;
                        r_state   <= ST_RECV;
                    end else if (alloc_fail) begin
                        alloc_req       <= 1'b0;
                        error_code      <= c_ERR_ALLOC;
                        clear_rx_buffer <= 1'b1;
                        r_state         <= ST_ERROR;
                    end
                end

                ST_RECV: begin
                    if (rx_valid) begin
                        mem_wr_en   <= 1'b1;
                        mem_wr_addr <= w_wr_addr;
                        mem_wr_data <= w_elem;
                        r_idx       <= r_idx + 8'd1;
                        r_timeout   <= 32'd0;
                        if (r_idx == r_total - 8'd1) begin
                            r_state <= ST_COMMIT;
                        end
                    end else if (w_timeout_hit) begin
                        error_code      <= c_ERR_TIMEOUT;
                        clear_rx_buffer <= 1'b1;
                        r_state         <= ST_ERROR;
                    end else begin
                        r_timeout <= r_timeout + 32'd1;
                    end
                end

                // Commit follows the final write so the slot never advertises unwritten data.
                ST_COMMIT: begin
                    commit_valid <= 1'b1;
                    commit_slot  <= r_slot;
                    r_state      <= ST_SEND;
                end

                ST_SEND: begin
                    if (!tx_busy) begin
                        tx_data  <= c_TX_OK;
                        tx_start <= 1'b1;
                        r_state  <= ST_DONE;
                    end
                end

                ST_DONE: begin
                    r_state <= ST_DONE;
                end

                ST_ERROR: begin
                    if (!tx_busy) begin
                        tx_data  <= c_TX_ERR;
                        tx_start <= 1'b1;
                        r_state  <= ST_DONE;
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
